// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sipo.sv
// Serial-in/parallel-out shift register, LSB-first: new bits enter at the MSB.
module sipo #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_data
);

  // Shift right on enable so the first received bit ends up in bit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      o_data <= '0;
    else if (i_shift)
      o_data <= {i_din, o_data[WIDTH-1:1]};
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte + error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_par_en,
  input  logic                 i_par_typ,
  output logic [DATA_BITS-1:0] o_p_data,
  output logic                 o_data_valid,
  output logic                 o_par_err,
  output logic                 o_stop_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  // Down-counter loads: first sample half a bit after the edge, then one full bit apart.
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t             state, state_nxt;
  logic                  rx_m, rx_s, rx_prev;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q, par_typ_q, par_bad;
  logic                  start_det, tick;
  logic                  shift_en, sipo_clr, done;
  logic [DATA_BITS-1:0]  sh_data;

  assign start_det = rx_prev & ~rx_s;
  assign tick      = (clk_cnt == '0);

  // Synchronize the asynchronous line; idle level is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= i_rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Next-state logic; each non-idle state acts only on its sample tick.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    sipo_clr  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nxt = START;
          sipo_clr  = 1'b1;
        end
      end
      START: begin
        // A high line at mid-start means a glitch: drop back silently.
        if (tick) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is not missed.
        if (tick) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, bit/clock counters, latched frame options and parity result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (start_det) begin
          clk_cnt   <= HALF_LD;
          bit_cnt   <= '0;
          par_en_q  <= i_par_en;
          par_typ_q <= i_par_typ;
          par_bad   <= 1'b0;
        end else begin
          clk_cnt <= '0;
        end
      end else if (state_nxt == IDLE) begin
        clk_cnt <= '0;
      end else if (tick) begin
        clk_cnt <= FULL_LD;
      end else begin
        clk_cnt <= clk_cnt - 1'b1;
      end
      if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      // Sampled parity bit must equal data XOR (inverted for odd parity).
      if (state == PARITY && tick)
        par_bad <= rx_s ^ (^sh_data) ^ (par_typ_q == PAR_ODD);
    end
  end

  sipo #(.WIDTH(DATA_BITS)) u_sipo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (sipo_clr),
    .i_shift (shift_en),
    .i_din   (rx_s),
    .o_data  (sh_data)
  );

  // Output registers: data and flags update together with the valid pulse.
  // Busy stays up through the valid cycle but drops immediately on a glitch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p_data     <= '0;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_stop_err   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_data_valid <= done;
      o_busy       <= (state_nxt != IDLE) | done;
      if (done) begin
        o_p_data   <= sh_data;
        o_par_err  <= par_en_q & par_bad;
        o_stop_err <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed corner frames plus random frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int LOGN = 20000;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_par_en = 1'b0;
  logic       i_par_typ = 1'b0;
  logic [7:0] o_p_data;
  logic       o_data_valid, o_par_err, o_stop_err, o_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic busy_log  [LOGN];
  logic valid_log [LOGN];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .i_par_en     (i_par_en),
    .i_par_typ    (i_par_typ),
    .o_p_data     (o_p_data),
    .o_data_valid (o_data_valid),
    .o_par_err    (o_par_err),
    .o_stop_err   (o_stop_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic int nvalid(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < LOGN && valid_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic logb(input int i);
    return (i >= 0 && i < LOGN) ? busy_log[i] : 1'bx;
  endfunction

  // Drive one full frame starting this cycle and push what the receiver must report.
  // Parity rule: total ones over data+parity is even for even parity, odd for odd.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic pbit, input logic sbit, output int f);
    exp_t e;
    i_par_en  = pe;
    i_par_typ = pt;
    i_rx      = 1'b0;
    f         = cyc;
    e.data = d;
    e.perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
    e.serr = !sbit;
    // two sync flops, half bit to start centre, remaining bit centres, one output register
    e.at   = f + 2 + CPB / 2 + (pe ? 10 : 9) * CPB + 1;
    sb.push_back(e);
    tick(4);
    // options are latched at start detection; later changes must be ignored
    i_par_en  = 1'($urandom);
    i_par_typ = 1'($urandom);
    tick(CPB - 4);
    for (int k = 0; k < 8; k++) begin
      i_rx = d[k];
      tick(CPB);
    end
    if (pe) begin
      i_rx = pbit;
      tick(CPB);
    end
    i_rx = sbit;
    tick(CPB);
  endtask

  // Monitor: log per-cycle outputs and check every valid pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (cyc < LOGN) begin
        busy_log[cyc]  = o_busy;
        valid_log[cyc] = o_data_valid;
      end
      if (o_data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(o_p_data), 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("valid_cycle", cyc, e.at);
          chk("p_data", 32'(o_p_data), 32'(e.data));
          chk("par_err", 32'(o_par_err), 32'(e.perr));
          chk("stop_err", 32'(o_stop_err), 32'(e.serr));
        end
      end
    end
  end

  initial begin
    int f, f2;
    logic [7:0] rd;
    logic rpe, rpt, rpb, rsb;

    // Reset state
    tick(3);
    chk("rst_p_data", 32'(o_p_data), 0);
    chk("rst_valid", 32'(o_data_valid), 0);
    chk("rst_par_err", 32'(o_par_err), 0);
    chk("rst_stop_err", 32'(o_stop_err), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    tick(5);

    // Basic frame with busy window
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, f);
    i_rx = 1'b1;
    tick(20);
    chk("busy_before", 32'(logb(f + 2)), 0);
    chk("busy_rise", 32'(logb(f + 3)), 1);
    chk("busy_last", 32'(logb(f + 155)), 1);
    chk("busy_fall", 32'(logb(f + 156)), 0);
    chk("no_early_valid", nvalid(f, f + 154), 0);

    // Parity variants on 0x03
    send(8'h03, 1'b1, PAR_EVEN, 1'b1, 1'b1, f); i_rx = 1'b1; tick(10);
    send(8'h03, 1'b1, PAR_EVEN, 1'b0, 1'b1, f); i_rx = 1'b1; tick(10);
    send(8'h03, 1'b1, PAR_ODD,  1'b1, 1'b1, f); i_rx = 1'b1; tick(10);

    // Stop error, line then held low: no new frame without a fresh falling edge
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, f);
    tick(40);
    i_rx = 1'b1;
    tick(60);
    chk("no_valid_after_low", nvalid(f + 156, cyc - 1), 0);

    // Glitch on the line
    i_rx = 1'b0;
    f = cyc;
    tick(4);
    i_rx = 1'b1;
    tick(30);
    chk("glitch_busy_up", 32'(logb(f + 3)), 1);
    chk("glitch_busy_down", 32'(logb(f + 11)), 0);
    chk("glitch_no_valid", nvalid(f, cyc - 1), 0);
    chk("glitch_data_held", 32'(o_p_data), 32'h5A);

    // Back-to-back frames
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, f);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, f2);
    i_rx = 1'b1;
    tick(20);

    // Reset during data bit 4, then a clean frame
    rd = 8'h5F;
    i_par_en = 1'b0;
    i_rx = 1'b0;
    f = cyc;
    tick(CPB);
    for (int k = 0; k < 4; k++) begin
      i_rx = rd[k];
      tick(CPB);
    end
    i_rx = rd[4];
    tick(2);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    chk("mid_rst_p_data", 32'(o_p_data), 0);
    chk("mid_rst_valid", 32'(o_data_valid), 0);
    chk("mid_rst_par_err", 32'(o_par_err), 0);
    chk("mid_rst_stop_err", 32'(o_stop_err), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    i_rx = 1'b1;
    tick(60);
    chk("mid_rst_no_valid", nvalid(f, cyc - 1), 0);
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, f);
    i_rx = 1'b1;
    tick(20);

    // Random frames
    for (int n = 0; n < 14; n++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rpb = 1'($urandom);
      rsb = ($urandom_range(0, 3) != 0);
      send(rd, rpe, rpt, rpb, rsb, f);
      i_rx = 1'b1;
      tick(rsb ? $urandom_range(0, 6) : $urandom_range(2, 6));
    end

    i_rx = 1'b1;
    tick(200);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
